// File: rtl/arbiter_rr_lock.sv
// Round-robin packet arbiter: locks a grant for a whole packet, releases on the
// last accepted beat or on watchdog expiry, and re-arbitrates without a bubble.
module arbiter_rr_lock #(
  parameter int NUM_PORTS      = 3,
  parameter int SEL_W          = $clog2(NUM_PORTS),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 beat_valid,
  input  logic                 beat_ready,
  input  logic                 beat_last,
  output logic                 grant_valid,
  output logic [SEL_W-1:0]     grant_sel,
  output logic [NUM_PORTS-1:0] grant_onehot,
  output logic                 timeout_pulse,
  output logic [SEL_W-1:0]     timeout_port
);

  localparam int              WD_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [WD_W-1:0] WD_SAT   = '1;
  localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(NUM_PORTS - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                 state_q, state_nxt;
  logic [SEL_W-1:0]       last_port, last_nxt;
  logic [WD_W-1:0]        wd_cnt, wd_nxt;
  logic                   gv_nxt, tp_nxt;
  logic [SEL_W-1:0]       sel_nxt, tport_nxt;
  logic [NUM_PORTS-1:0]   oh_nxt;

  logic                   accept, any_req, wd_expire, rel;
  logic [SEL_W-1:0]       win;
  logic [NUM_PORTS-1:0]   win_onehot;

  // Ascending search with wrap starting just after the previous winner.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] r,
                                               input logic [SEL_W-1:0]     last);
    logic [SEL_W-1:0]     w;
    logic                 found;
    logic [NUM_PORTS-1:0] sh;
    int                   idx;
    w     = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = (int'(last) + i) % NUM_PORTS;
      sh  = r >> idx;
      if (!found && sh[0]) begin
        found = 1'b1;
        w     = SEL_W'(idx);
      end
    end
    return w;
  endfunction

  assign accept     = beat_valid & beat_ready;
  assign any_req    = |req;
  assign win        = rr_pick(req, last_port);
  assign win_onehot = NUM_PORTS'(1) << win;
  assign wd_expire  = (TIMEOUT_CYCLES != 0) && (state_q == LOCKED) && !accept && (wd_cnt == WD_LAST);
  assign rel        = (state_q == LOCKED) && ((accept && beat_last) || wd_expire);

  always_comb begin
    state_nxt = state_q;
    gv_nxt    = grant_valid;
    sel_nxt   = grant_sel;
    oh_nxt    = grant_onehot;
    last_nxt  = last_port;
    wd_nxt    = wd_cnt;
    tp_nxt    = 1'b0;
    tport_nxt = timeout_port;
    case (state_q)
      IDLE: begin
        wd_nxt = '0;
        if (any_req) begin
          state_nxt = LOCKED;
          gv_nxt    = 1'b1;
          sel_nxt   = win;
          oh_nxt    = win_onehot;
          last_nxt  = win;
        end
      end
      LOCKED: begin
        if (rel) begin
          wd_nxt = '0;
          if (wd_expire) begin
            tp_nxt    = 1'b1;
            tport_nxt = grant_sel;
          end
          if (any_req) begin
            sel_nxt  = win;
            oh_nxt   = win_onehot;
            last_nxt = win;
          end else begin
            state_nxt = IDLE;
            gv_nxt    = 1'b0;
            oh_nxt    = '0;
          end
        end else if (accept) begin
          wd_nxt = '0;
        end else if ((TIMEOUT_CYCLES != 0) && (wd_cnt != WD_SAT)) begin
          wd_nxt = wd_cnt + WD_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_valid   <= 1'b0;
      grant_sel     <= '0;
      grant_onehot  <= '0;
      last_port     <= LAST_RST;
      wd_cnt        <= '0;
      timeout_pulse <= 1'b0;
      timeout_port  <= '0;
    end else begin
      state_q       <= state_nxt;
      grant_valid   <= gv_nxt;
      grant_sel     <= sel_nxt;
      grant_onehot  <= oh_nxt;
      last_port     <= last_nxt;
      wd_cnt        <= wd_nxt;
      timeout_pulse <= tp_nxt;
      timeout_port  <= tport_nxt;
    end
  end

endmodule

// File: doc/arbiter_rr_lock.md
# arbiter_rr_lock

Parametrised round-robin packet arbiter for the packet switcher's output stage. It selects one of NUM_PORTS requesting input ports and holds that grant for a whole packet, releasing it after the last beat is accepted downstream. A watchdog forces release of a stalled grant. It drives the select lines of the output mux, so port count is no longer fixed at three and packets are never interleaved.

## Interface
- NUM_PORTS, 3: number of input ports; legal range 2..16.
- SEL_W, $clog2(NUM_PORTS): width of the encoded select.
- TIMEOUT_CYCLES, 1024: idle cycles allowed inside a locked grant before forced release; 0 disables the watchdog.
- clk  in  1  sole clock; everything is on the rising edge.
- reset  in  1  one clock; reset is asynchronous and active-high.
- req  in  NUM_PORTS  bit i high: port i has a packet head pending.
- beat_valid  in  1  valid on the mux output (granted port's stream).
- beat_ready  in  1  ready from downstream of the mux.
- beat_last  in  1  last beat of the packet; qualified by beat_valid & beat_ready.
- grant_valid  out  1  a port is currently granted (locked).
- grant_sel  out  SEL_W  encoded granted port; meaningful only when grant_valid=1.
- grant_onehot  out  NUM_PORTS  one-hot granted port; all-zero when grant_valid=0.
- timeout_pulse  out  1  one-cycle pulse on watchdog release.
- timeout_port  out  SEL_W  port released by the last watchdog event; holds until the next event.

## Operation
- Define accept = beat_valid & beat_ready, and release = accept & beat_last, or a watchdog expiry.
- The FSM has two states, IDLE and LOCKED. All outputs are registered.
- Arbitration function: search req starting at port (last_port+1) mod NUM_PORTS, ascending with wrap. The first set bit wins, so the previous winner has the lowest priority.
- last_port is updated on every new grant. Its reset value is NUM_PORTS-1, so port 0 has the highest priority after reset.
- IDLE: if any req bit is set, register the winner in grant_sel/grant_onehot, set grant_valid, update last_port, and go to LOCKED. Otherwise stay in IDLE with outputs deasserted.
- LOCKED: the grant is frozen and req changes are ignored, including deassertion by the granted port.
- On release in LOCKED, with req excluding nothing (the just-released port is eligible only if no other port requests):
  - If any req bit is set, re-arbitrate in the same cycle and load the new winner, staying in LOCKED. This gives back-to-back packets with no bubble.
  - Otherwise go to IDLE and clear grant_valid and grant_onehot.
- Single-beat packets (beat_last on the first accept) are legal.
- Watchdog: a counter is cleared on entering or re-entering LOCKED and on every accept. It increments in every LOCKED cycle without an accept.
  - When the counter equals TIMEOUT_CYCLES-1 in a cycle with no accept, the block releases on that edge, pulses timeout_pulse, and loads timeout_port with the released port.
  - Re-arbitration then follows the normal release rule.
- An accept in the expiry cycle takes precedence: the counter clears and no timeout occurs.
- When TIMEOUT_CYCLES=0 the counter is not incremented and timeout_pulse never asserts.
- Counter width is $clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.
- accept while in IDLE is ignored. It is a protocol error, and the datapath guarantees beat_valid=0 when grant_valid=0.

## Timing
- Reset values: grant_valid=0, grant_sel=0, grant_onehot=0, timeout_pulse=0, timeout_port=0, state IDLE, last_port=NUM_PORTS-1, watchdog=0.
- Reset asserted mid-packet drops the grant immediately (asynchronously). The first grant after reset deassertion again favours port 0.
- Request-to-grant latency: req sampled high in IDLE at edge k gives grant_valid=1 after edge k.
- Release-to-next-grant: 0 idle cycles. The new grant_sel appears after the same edge that samples the releasing accept.
- Release-to-idle: grant_valid falls after the edge sampling release.
- Watchdog: with the grant loaded at edge g and no accepts, timeout_pulse is high for exactly the cycle after edge g+TIMEOUT_CYCLES.
- grant_sel and grant_onehot change only on grant load or release edges.

## Test plan
- Reset, then req=3'b111 held, one-beat packets every cycle (NUM_PORTS=3) -> grant_sel sequence 0,1,2,0,1,2 with grant_valid continuously high.
- req=3'b010 only, a 4-beat packet with beat_ready toggling 1,0,1,0… -> grant stays on port 1 until the 4th accept; during the packet, req[0] rising does not move the grant; port 0 is granted on the release edge.
- Single requester port 2, back-to-back packets -> port 2 re-granted each time with no gap; when req drops, grant_valid=0 one edge after the last release.
- TIMEOUT_CYCLES=8, port 1 granted, beat_valid=0 -> timeout_pulse high exactly 8 cycles after the grant, timeout_port=1, then the next requester is granted; an accept arriving in cycle 8 instead suppresses the timeout.
- Assert reset during beat 2 of a 5-beat packet on port 1 -> all outputs go to 0 without a clock edge; after deassertion with req=3'b110, port 1 is granted first.
- NUM_PORTS=5, req=5'b10001 after a grant on port 4 -> port 0 wins, then port 4, alternating; verify grant_onehot always matches grant_sel.
